// File: rtl/ss_sg_pkg.sv
// Shared encodings for the ss_sg_burst scatter-gather master.
package ss_sg_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_D_REQ  = 4'd1,
    S_B_WAIT = 4'd2,
    S_B_REQ  = 4'd3,
    S_NEXT   = 4'd4,
    S_END    = 4'd5,
    S_PANIC  = 4'd6,
    S_WRB    = 4'd7
  } sg_state_t;

  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_BUS   = 3'd1;
  localparam logic [2:0] ERR_RTY   = 3'd2;
  localparam logic [2:0] ERR_ABORT = 3'd4;

  localparam int unsigned LAST_BIT = 20;
  localparam int unsigned LEN_LSB  = 3;

endpackage

// File: rtl/ss_sg_addr_cnt.sv
// Loadable 29-bit word address register with increment; wraps modulo 2^29.
module ss_sg_addr_cnt (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        load,
  input  logic        inc,
  input  logic [28:0] load_val,
  output logic [28:0] addr
);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)  addr <= '0;
    else if (load) addr <= load_val;
    else if (inc)  addr <= addr + 29'd1;
  end

endmodule

// File: rtl/ss_sg_burst.sv
// Scatter-gather burst master: walks a descriptor chain over 64-bit Wishbone.
// Optional descriptor done-bit writeback is enabled by SS_SG_DESC_WB_EN.
module ss_sg_burst
  import ss_sg_pkg::*;
#(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned RTY_MAX   = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [28:0] cmd_desc,
  input  logic        cmd_abort,
  output logic        wbs_cyc,
  output logic        wbs_stb,
  output logic        wbs_we,
  output logic        wbs_cab,
  output logic [3:0]  wbs_sel,
  output logic [31:0] wbs_adr,
  output logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_dat_o,
  input  logic [31:0] wbs_dat64_o,
  input  logic        wbs_ack,
  input  logic        wbs_err,
  input  logic        wbs_rty,
  input  logic        ss_start,
  input  logic        ss_stop,
  output logic        ss_xfer,
  output logic        ss_last,
  output logic        done,
  output logic [2:0]  err_code,
  output logic [7:0]  sg_state
);

  localparam int unsigned     BC_W     = $clog2(MAX_BURST) + 1;
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(MAX_BURST - 1);
  localparam logic [7:0]      RTY_LAST = 8'(RTY_MAX - 1);

  sg_state_t state, state_nxt;

  logic             rw_q, last_q, d_beat;
  logic [LEN_W-1:0] len_q;
  logic [BC_W-1:0]  bcnt;
  logic [7:0]       rty_cnt;
  logic [28:0]      next_q, desc_q;

  logic        adr_ld, adr_inc, buf_ld, buf_inc;
  logic [28:0] adr_val, adr_q, buf_q;
  logic        err_ld;
  logic [2:0]  err_nxt;

  logic bus_st, wrb_st, abort_now, ack_e, err_e, rty_e, len_done;
  logic unused_bits;

`ifdef SS_SG_DESC_WB_EN
  assign wrb_st      = (state == S_WRB);
  assign unused_bits = ^{wbs_dat_o[2:0], wbs_dat64_o[2:0]};
`else
  assign wrb_st      = 1'b0;
  assign unused_bits = ^{wbs_dat_o[2:0], wbs_dat64_o[2:0], desc_q};
`endif

  assign bus_st    = (state == S_D_REQ) || (state == S_B_REQ) || wrb_st;
  assign abort_now = cmd_abort && (state != S_IDLE) && (state != S_END);
  assign err_e     = bus_st && !abort_now && wbs_err;
  assign ack_e     = bus_st && !abort_now && !wbs_err && wbs_ack;
  assign rty_e     = bus_st && !abort_now && !wbs_err && !wbs_ack && wbs_rty;
  assign len_done  = (len_q == LEN_W'(1));

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_END);
  assign wbs_adr   = {adr_q, 3'b000};
  assign wbs_sel   = wbs_cyc ? 4'hF : 4'h0;
  assign sg_state  = {last_q, 3'b000, state};

  ss_sg_addr_cnt u_wb_adr (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .load     (adr_ld),
    .inc      (adr_inc),
    .load_val (adr_val),
    .addr     (adr_q)
  );

  ss_sg_addr_cnt u_buf_adr (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .load     (buf_ld),
    .inc      (buf_inc),
    .load_val (wbs_dat64_o[31:3]),
    .addr     (buf_q)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wbs_cyc   = 1'b0;
    wbs_stb   = 1'b0;
    wbs_we    = 1'b0;
    wbs_cab   = 1'b0;
    wbs_dat_i = '0;
    ss_xfer   = 1'b0;
    ss_last   = 1'b0;
    adr_ld    = 1'b0;
    adr_inc   = 1'b0;
    adr_val   = adr_q;
    buf_ld    = 1'b0;
    buf_inc   = 1'b0;
    err_ld    = 1'b0;
    err_nxt   = err_code;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = S_D_REQ;
          adr_ld    = 1'b1;
          adr_val   = cmd_desc;
          err_ld    = 1'b1;
          err_nxt   = ERR_OK;
        end
      end
      S_D_REQ: begin
        wbs_cyc = 1'b1;
        wbs_stb = 1'b1;
        wbs_cab = 1'b1;
        if (ack_e) begin
          adr_inc = 1'b1;
          if (!d_beat) buf_ld = 1'b1;
          else         state_nxt = (len_q == '0) ? S_NEXT : S_B_WAIT;
        end
      end
      S_B_WAIT: begin
        if (ss_start) begin
          state_nxt = S_B_REQ;
          adr_ld    = 1'b1;
          adr_val   = buf_q;
        end
      end
      S_B_REQ: begin
        wbs_cyc = 1'b1;
        wbs_stb = 1'b1;
        wbs_cab = 1'b1;
        wbs_we  = rw_q;
        if (ack_e) begin
          ss_xfer = 1'b1;
          ss_last = last_q && len_done;
          adr_inc = 1'b1;
          buf_inc = 1'b1;
          if (len_done) begin
`ifdef SS_SG_DESC_WB_EN
            state_nxt = S_WRB;
            adr_ld    = 1'b1;
            adr_val   = desc_q;
`else
            state_nxt = S_NEXT;
`endif
          end else if ((bcnt == BC_LAST) || ss_stop) begin
            state_nxt = S_B_WAIT;
          end
        end
      end
`ifdef SS_SG_DESC_WB_EN
      S_WRB: begin
        wbs_cyc   = 1'b1;
        wbs_stb   = 1'b1;
        wbs_cab   = 1'b1;
        wbs_we    = 1'b1;
        wbs_dat_i = {11'b0, 1'b1, 20'b0};
        if (ack_e) state_nxt = S_NEXT;
      end
`endif
      S_NEXT: begin
        if (last_q) begin
          state_nxt = S_END;
        end else begin
          state_nxt = S_D_REQ;
          adr_ld    = 1'b1;
          adr_val   = next_q;
        end
      end
      S_END:   state_nxt = S_IDLE;
      S_PANIC: state_nxt = S_PANIC;
      default: state_nxt = S_IDLE;
    endcase

    // Abort beats every bus termination; the ack gating above already drops its beat.
    if (abort_now) begin
      state_nxt = S_END;
      err_ld    = 1'b1;
      err_nxt   = ERR_ABORT;
    end else if (err_e) begin
      state_nxt = S_PANIC;
      err_ld    = 1'b1;
      err_nxt   = ERR_BUS;
    end else if (rty_e && (rty_cnt == RTY_LAST)) begin
      state_nxt = S_PANIC;
      err_ld    = 1'b1;
      err_nxt   = ERR_RTY;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_code <= ERR_OK;
      rw_q     <= 1'b0;
      last_q   <= 1'b0;
      d_beat   <= 1'b0;
      len_q    <= '0;
      bcnt     <= '0;
      rty_cnt  <= '0;
      next_q   <= '0;
      desc_q   <= '0;
    end else begin
      if (err_ld) err_code <= err_nxt;
      if ((state == S_IDLE) && cmd_valid) begin
        rw_q    <= cmd_rw;
        desc_q  <= cmd_desc;
        d_beat  <= 1'b0;
        rty_cnt <= '0;
      end else begin
        if ((state == S_NEXT) && !last_q) begin
          desc_q <= next_q;
          d_beat <= 1'b0;
        end
        if ((state == S_D_REQ) && ack_e) begin
          d_beat <= 1'b1;
          if (!d_beat) begin
            last_q <= wbs_dat_o[LAST_BIT];
            len_q  <= wbs_dat_o[LEN_LSB +: LEN_W];
          end else begin
            next_q <= wbs_dat_o[31:3];
          end
        end
        if ((state == S_B_WAIT) && ss_start) bcnt <= '0;
        if (ss_xfer) begin
          len_q <= len_q - LEN_W'(1);
          bcnt  <= bcnt + BC_W'(1);
        end
        if (ack_e)      rty_cnt <= '0;
        else if (rty_e) rty_cnt <= rty_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ss_sg_burst.sv
// Self-checking bench for ss_sg_burst: Wishbone memory slave, FIFO pacing and a chain-level model.
module tb_ss_sg_burst;

  localparam int unsigned MAXB = 16;
  localparam int unsigned RTYM = 3;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0, cmd_rw = 1'b0, cmd_abort = 1'b0;
  logic [28:0] cmd_desc = '0;
  logic        cmd_ready;
  logic        wbs_cyc, wbs_stb, wbs_we, wbs_cab;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr, wbs_dat_i;
  logic [31:0] wbs_dat_o = '0, wbs_dat64_o = '0;
  logic        wbs_ack = 1'b0, wbs_err = 1'b0, wbs_rty = 1'b0;
  logic        ss_start = 1'b0, ss_stop = 1'b0;
  logic        ss_xfer, ss_last, done;
  logic [2:0]  err_code;
  logic [7:0]  sg_state;

  always #5 wb_clk_i = ~wb_clk_i;

  ss_sg_burst #(.LEN_W(16), .MAX_BURST(MAXB), .RTY_MAX(RTYM)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_desc(cmd_desc), .cmd_abort(cmd_abort),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we), .wbs_cab(wbs_cab),
    .wbs_sel(wbs_sel), .wbs_adr(wbs_adr), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_dat64_o(wbs_dat64_o),
    .wbs_ack(wbs_ack), .wbs_err(wbs_err), .wbs_rty(wbs_rty),
    .ss_start(ss_start), .ss_stop(ss_stop), .ss_xfer(ss_xfer), .ss_last(ss_last),
    .done(done), .err_code(err_code), .sg_state(sg_state)
  );

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // memory word = {high word, low word}
  logic [63:0] mem [logic [28:0]];

  bit          rand_slave = 0, fifo_rand = 0, err_arm = 0;
  logic [28:0] rty_adr = '0, err_adr = '0;
  int          rty_left = 0, rty_run = 0;

  logic [31:0] obs_adr[$], obs_dat[$];
  bit          obs_we[$];
  int          obs_bursts[$];
  int          obs_xfer, obs_last, last_idx, obs_done, run_x;

  logic [31:0] exp_adr[$], exp_dat[$];
  bit          exp_we[$];
  int          exp_bursts[$];
  int          exp_xfer;

  // Slave, FIFO pacing and monitor: inputs change on negedge, outputs sampled 1 later.
  always @(negedge wb_clk_i) begin
    logic [28:0] a;
    logic [63:0] d;
    int          r;
    wbs_ack = 1'b0; wbs_err = 1'b0; wbs_rty = 1'b0;
    if (fifo_rand) begin
      ss_start = ($urandom_range(0, 3) != 0);
      ss_stop  = ($urandom_range(0, 5) == 0);
    end else begin
      ss_start = 1'b1;
      ss_stop  = 1'b0;
    end
    a = wbs_adr[31:3];
    d = mem.exists(a) ? mem[a] : {3'b0, a, 3'b0, ~a};
    wbs_dat_o   = d[31:0];
    wbs_dat64_o = d[63:32];
    if (!wb_rst_i && wbs_cyc && wbs_stb) begin
      if (err_arm && a == err_adr) begin
        wbs_err = 1'b1;
        err_arm = 0;
      end else if (rty_left > 0 && a == rty_adr) begin
        wbs_rty = 1'b1;
        rty_left--;
      end else if (rand_slave) begin
        r = $urandom_range(0, 7);
        if (r < 2) begin
        end else if (r == 2 && rty_run < int'(RTYM) - 1) begin
          wbs_rty = 1'b1;
          rty_run++;
        end else wbs_ack = 1'b1;
      end else wbs_ack = 1'b1;
      if (wbs_ack) begin
        rty_run = 0;
        obs_adr.push_back(wbs_adr);
        obs_we.push_back(wbs_we);
        obs_dat.push_back(wbs_dat_i);
        check("sel", wbs_sel, 4'hF);
        check("cab", wbs_cab, 1);
      end
    end
    #1;
    if (ss_xfer) begin
      obs_xfer++;
      run_x++;
      if (ss_last) begin
        obs_last++;
        last_idx = obs_xfer - 1;
      end
    end else if (ss_last) obs_last++;
    if (done) obs_done++;
    if (!wbs_cyc && run_x > 0) begin
      obs_bursts.push_back(run_x);
      run_x = 0;
    end
  end

  task automatic clear_exp();
    exp_adr.delete(); exp_dat.delete(); exp_we.delete(); exp_bursts.delete();
    exp_xfer = 0;
  endtask

  // Writes one descriptor to memory and appends the bus beats it must produce.
  task automatic add_desc(input logic [28:0] da, input int unsigned len, input bit last,
                          input logic [28:0] bufa, input logic [28:0] nxt, input bit rw);
    logic [31:0] lo;
    logic [28:0] w;
    int          rem;
    lo     = '0;
    lo[20] = last;
    lo[18:3] = len[15:0];
    mem[da] = {bufa, 3'b0, lo};
    mem[da + 29'd1] = {32'h0, nxt, 3'b0};
    exp_adr.push_back({da, 3'b0});         exp_we.push_back(0); exp_dat.push_back(0);
    exp_adr.push_back({da + 29'd1, 3'b0}); exp_we.push_back(0); exp_dat.push_back(0);
    for (int i = 0; i < int'(len); i++) begin
      w = bufa + 29'(i);
      exp_adr.push_back({w, 3'b0}); exp_we.push_back(rw); exp_dat.push_back(0);
    end
`ifdef SS_SG_DESC_WB_EN
    if (len > 0) begin
      exp_adr.push_back({da, 3'b0}); exp_we.push_back(1); exp_dat.push_back(32'h0010_0000);
    end
`endif
    exp_xfer += int'(len);
    rem = int'(len);
    while (rem > 0) begin
      exp_bursts.push_back(rem > int'(MAXB) ? int'(MAXB) : rem);
      rem -= int'(MAXB);
    end
  endtask

  task automatic start_job(input logic [28:0] d0, input bit rw);
    @(negedge wb_clk_i); #2;
    obs_adr.delete(); obs_dat.delete(); obs_we.delete(); obs_bursts.delete();
    obs_xfer = 0; obs_last = 0; last_idx = -1; obs_done = 0; run_x = 0; rty_run = 0;
    check("ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_desc = d0;
    @(negedge wb_clk_i); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n = 0;
    while (obs_done == 0 && n < limit) begin
      @(negedge wb_clk_i); #3;
      n++;
    end
    check({tag, "_done_seen"}, obs_done != 0, 1);
  endtask

  task automatic wait_err(input int limit);
    int n = 0;
    while (err_code == 3'd0 && n < limit) begin
      @(negedge wb_clk_i); #3;
      n++;
    end
  endtask

  task automatic finish_job(input string tag);
    int n;
    wait_done(4000, tag);
    repeat (2) @(negedge wb_clk_i);
    #3;
    check({tag, "_nbeats"}, obs_adr.size(), exp_adr.size());
    n = (obs_adr.size() < exp_adr.size()) ? obs_adr.size() : exp_adr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_adr%0d", tag, i), obs_adr[i], exp_adr[i]);
      check($sformatf("%s_we%0d", tag, i), obs_we[i], exp_we[i]);
      check($sformatf("%s_dat%0d", tag, i), obs_dat[i], exp_dat[i]);
    end
    check({tag, "_xfer"}, obs_xfer, exp_xfer);
    check({tag, "_nlast"}, obs_last, 1);
    check({tag, "_last_idx"}, last_idx, exp_xfer - 1);
    check({tag, "_ndone"}, obs_done, 1);
    check({tag, "_err"}, err_code, 0);
    check({tag, "_idle"}, cmd_ready, 1);
    if (!fifo_rand) begin
      check({tag, "_nbursts"}, obs_bursts.size(), exp_bursts.size());
      for (int i = 0; i < obs_bursts.size() && i < exp_bursts.size(); i++)
        check($sformatf("%s_burst%0d", tag, i), obs_bursts[i], exp_bursts[i]);
    end else begin
      foreach (obs_bursts[i])
        check($sformatf("%s_burst_le%0d", tag, i), obs_bursts[i] <= int'(MAXB), 1);
    end
  endtask

  task automatic abort_job(input string tag);
    @(negedge wb_clk_i); #2;
    cmd_abort = 1'b1;
    @(negedge wb_clk_i); #2;
    cmd_abort = 1'b0;
    wait_done(20, tag);
    repeat (2) @(negedge wb_clk_i);
    #3;
    check({tag, "_err4"}, err_code, 3'd4);
    check({tag, "_ndone"}, obs_done, 1);
    check({tag, "_idle"}, cmd_ready, 1);
  endtask

  initial begin
    int          nd, ln;
    logic [28:0] base, b;
    bit          rw;

    #12;
    check("rst_cyc", wbs_cyc, 0);
    check("rst_done", done, 0);
    check("rst_err", err_code, 0);
    check("rst_state", sg_state, 0);
    @(negedge wb_clk_i); #2;
    wb_rst_i = 1'b0;

    // single descriptor, 4 beats at 0x1000
    clear_exp();
    add_desc(29'h100, 4, 1, 29'h200, 29'h0, 0);
    start_job(29'h100, 0);
    finish_job("single");

    // 40 beats split 16/16/8 at 0x2000
    clear_exp();
    add_desc(29'h110, 40, 1, 29'h400, 29'h0, 1);
    start_job(29'h110, 1);
    finish_job("split");

    // zero-length descriptor skipped
    clear_exp();
    add_desc(29'h120, 0, 0, 29'h480, 29'h130, 0);
    add_desc(29'h130, 2, 1, 29'h500, 29'h0, 0);
    start_job(29'h120, 0);
    finish_job("zskip");

    // retry overflow on first data beat, then abort
    clear_exp();
    add_desc(29'h140, 4, 1, 29'h600, 29'h0, 0);
    rty_adr = 29'h600; rty_left = 3;
    start_job(29'h140, 0);
    wait_err(50);
    repeat (3) @(negedge wb_clk_i);
    #3;
    check("rty_err", err_code, 3'd2);
    check("rty_cyc", wbs_cyc, 0);
    check("rty_panic", sg_state[3:0], 4'd6);
    check("rty_xfer", obs_xfer, 0);
    check("rty_nodone", obs_done, 0);
    abort_job("rty_abort");

    // bus error on descriptor fetch, then abort
    clear_exp();
    add_desc(29'h150, 4, 1, 29'h700, 29'h0, 0);
    err_adr = 29'h150; err_arm = 1;
    start_job(29'h150, 0);
    wait_err(50);
    #10;
    check("berr_err", err_code, 3'd1);
    check("berr_cyc", wbs_cyc, 0);
    check("berr_xfer", obs_xfer, 0);
    check("berr_nodone", obs_done, 0);
    abort_job("berr_abort");

    // randomized chains with random slave waits/retries and FIFO pacing
    fifo_rand = 1; rand_slave = 1;
    for (int j = 0; j < 8; j++) begin
      clear_exp();
      nd   = $urandom_range(1, 4);
      base = 29'h10000 + 29'(j * 32);
      rw   = 1'($urandom_range(0, 1));
      for (int i = 0; i < nd; i++) begin
        ln = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
        if (i == nd - 1 && ln == 0) ln = 1;
        b = ($urandom_range(0, 3) == 0) ? 29'h1FFF_FFF0 + 29'($urandom_range(0, 15))
                                        : 29'($urandom());
        add_desc(base + 29'(i * 4), ln, i == nd - 1, b, base + 29'((i + 1) * 4), rw);
      end
      start_job(base, rw);
      finish_job($sformatf("rnd%0d", j));
    end
    fifo_rand = 0; rand_slave = 0;

    // reset asserted mid-burst
    clear_exp();
    add_desc(29'h160, 200, 1, 29'h800, 29'h0, 0);
    start_job(29'h160, 0);
    begin
      int n = 0;
      while (obs_xfer < 5 && n < 100) begin
        @(negedge wb_clk_i); #3;
        n++;
      end
    end
    check("mid_reached", obs_xfer >= 5, 1);
    @(negedge wb_clk_i); #2;
    wb_rst_i = 1'b1;
    #1;
    check("mid_rst_cyc", wbs_cyc, 0);
    check("mid_rst_state", sg_state, 0);
    check("mid_rst_done", done, 0);
    repeat (2) @(negedge wb_clk_i);
    #2;
    wb_rst_i = 1'b0;

    // recovery after reset
    clear_exp();
    add_desc(29'h170, 3, 1, 29'h900, 29'h0, 1);
    start_job(29'h170, 1);
    finish_job("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
